// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: opcodes, R-type function
// codes, sequencer states and the bubble control bundle.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_BLT   = 4'b0110;
    localparam logic [3:0] OP_JUMP  = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [3:0] FN_ADD = 4'hF;
    localparam logic [3:0] FN_SUB = 4'hE;
    localparam logic [3:0] FN_AND = 4'hD;
    localparam logic [3:0] FN_OR  = 4'hC;
    localparam logic [3:0] FN_MUL = 4'h1;
    localparam logic [3:0] FN_DIV = 4'h2;
    localparam logic [3:0] FN_SLL = 4'hA;
    localparam logic [3:0] FN_SRL = 4'hB;
    localparam logic [3:0] FN_ROL = 4'h8;
    localparam logic [3:0] FN_ROR = 4'h9;

    typedef enum logic [1:0] {S_RUN, S_MULDIV, S_HALT} state_t;

    typedef struct packed {
        logic       muxIF;
        logic       muxEXtop;
        logic       muxEXbottom;
        logic       muxWB;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       regWrite0;
        logic       comparator;
        logic [1:0] signExtend;
    } ctrl_t;

    // A bubble drives every control low and parks the ALU on function 1111.
    localparam ctrl_t      CTRL_BUBBLE = '0;
    localparam logic [3:0] FN_BUBBLE   = 4'hF;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/function code to control bundle
// plus classification flags used by the sequencer.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int FN_W = 4
) (
    input  logic [OP_W-1:0] oppcode,
    input  logic [FN_W-1:0] functionCode,
    output ctrl_t           ctrl,
    output logic [FN_W-1:0] fn,
    output logic            is_muldiv,
    output logic            is_halt,
    output logic            is_illegal
);

    always_comb begin
        ctrl       = CTRL_BUBBLE;
        fn         = FN_W'(FN_BUBBLE);
        is_muldiv  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (oppcode)
            OP_W'(OP_RTYPE): begin
                fn = functionCode;
                case (functionCode)
                    FN_W'(FN_ADD), FN_W'(FN_SUB), FN_W'(FN_AND), FN_W'(FN_OR): begin
                        ctrl.muxWB    = 1'b1;
                        ctrl.regWrite = 1'b1;
                    end
                    // mul/div results land in the dedicated result pair
                    FN_W'(FN_MUL), FN_W'(FN_DIV): begin
                        ctrl.muxWB     = 1'b1;
                        ctrl.regWrite0 = 1'b1;
                        is_muldiv      = 1'b1;
                    end
                    FN_W'(FN_SLL), FN_W'(FN_SRL), FN_W'(FN_ROL), FN_W'(FN_ROR): begin
                        ctrl.muxEXbottom = 1'b1;
                        ctrl.muxWB       = 1'b1;
                        ctrl.regWrite    = 1'b1;
                    end
                    default: begin
                        fn         = FN_W'(FN_BUBBLE);
                        is_illegal = 1'b1;
                    end
                endcase
            end
            OP_W'(OP_LOAD): begin
                ctrl.signExtend = 2'b01;
                ctrl.muxEXtop   = 1'b1;
                ctrl.memRead    = 1'b1;
                ctrl.regWrite   = 1'b1;
            end
            OP_W'(OP_STORE): begin
                ctrl.signExtend = 2'b01;
                ctrl.muxEXtop   = 1'b1;
                ctrl.memWrite   = 1'b1;
            end
            OP_W'(OP_BEQ), OP_W'(OP_BNE), OP_W'(OP_BLT): begin
                fn              = FN_W'(FN_SUB);
                ctrl.signExtend = 2'b10;
                ctrl.comparator = 1'b1;
            end
            OP_W'(OP_JUMP): begin
                ctrl.signExtend = 2'b11;
                ctrl.muxIF      = 1'b1;
            end
            OP_W'(OP_HALT): is_halt = 1'b1;
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control sequencer: registers the decoded bundle, stalls for
// multi-cycle mul/div, halts, squashes on taken branches.
// Build option ILLEGAL_TRAP_EN: illegal instructions halt the core with a sticky flag.
module pipe_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MULDIV_CYC = 4,
    parameter int OP_W       = 4,
    parameter int FN_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [OP_W-1:0] oppcode,
    input  logic [FN_W-1:0] functionCode,
    input  logic            branch_taken,
    input  logic            stall_in,
    output logic [FN_W-1:0] functCode,
    output logic [1:0]      signExtend,
    output logic            muxIF,
    output logic            muxEXtop,
    output logic            muxEXbottom,
    output logic            muxWB,
    output logic            memRead,
    output logic            memWrite,
    output logic            regWrite,
    output logic            regWrite0,
    output logic            comparator,
    output logic            valid_out,
    output logic            stall_out,
    output logic            halted,
    output logic            illegal
);

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYC - 1);

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    ctrl_t           ctrl_q, ctrl_nx, dec_ctrl;
    logic [FN_W-1:0] fn_q, fn_nx, dec_fn;
    logic            vld_nx, ill_nx;
    logic            dec_muldiv, dec_halt, dec_illegal;
    logic            accept;

    ctrl_decode #(.OP_W(OP_W), .FN_W(FN_W)) u_dec (
        .oppcode      (oppcode),
        .functionCode (functionCode),
        .ctrl         (dec_ctrl),
        .fn           (dec_fn),
        .is_muldiv    (dec_muldiv),
        .is_halt      (dec_halt),
        .is_illegal   (dec_illegal)
    );

    assign stall_out = (state != S_RUN);
    assign halted    = (state == S_HALT);
    assign accept    = valid_in & ~stall_in & ~stall_out & (state == S_RUN);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ctrl_nx  = ctrl_q;
        fn_nx    = fn_q;
        vld_nx   = valid_out;
        ill_nx   = illegal;
        // stall_in freezes both the sequencer and the output bundle
        if (!stall_in) begin
            ctrl_nx = CTRL_BUBBLE;
            fn_nx   = FN_W'(FN_BUBBLE);
            vld_nx  = 1'b0;
`ifndef ILLEGAL_TRAP_EN
            ill_nx  = 1'b0;
`endif
            case (state)
                S_RUN: begin
                    if (accept && !branch_taken) begin
                        if (dec_illegal) begin
                            ill_nx = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                            state_nx = S_HALT;
`endif
                        end else if (dec_halt) begin
                            state_nx = S_HALT;
                        end else begin
                            ctrl_nx = dec_ctrl;
                            fn_nx   = dec_fn;
                            vld_nx  = 1'b1;
                            if (dec_muldiv) begin
                                cnt_nx = MD_LOAD;
                                if (MD_LOAD != 4'd0) state_nx = S_MULDIV;
                            end
                        end
                    end
                end
                S_MULDIV: begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt_nx == 4'd0) state_nx = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            cnt       <= 4'd0;
            ctrl_q    <= CTRL_BUBBLE;
            fn_q      <= FN_W'(FN_BUBBLE);
            valid_out <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ctrl_q    <= ctrl_nx;
            fn_q      <= fn_nx;
            valid_out <= vld_nx;
            illegal   <= ill_nx;
        end
    end

    assign functCode   = fn_q;
    assign signExtend  = ctrl_q.signExtend;
    assign muxIF       = ctrl_q.muxIF;
    assign muxEXtop    = ctrl_q.muxEXtop;
    assign muxEXbottom = ctrl_q.muxEXbottom;
    assign muxWB       = ctrl_q.muxWB;
    assign memRead     = ctrl_q.memRead;
    assign memWrite    = ctrl_q.memWrite;
    assign regWrite    = ctrl_q.regWrite;
    assign regWrite0   = ctrl_q.regWrite0;
    assign comparator  = ctrl_q.comparator;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized and directed bench for pipe_ctrl_unit against a cycle-level
// reference model (remaining-stall counter, halt flag, decode table).
module tb_pipe_ctrl_unit;

    localparam int MDC = 4;

    localparam int K_OP = 0, K_MD = 1, K_HALT = 2, K_ILL = 3;
    // flag bit positions, ordered IF, EXtop, EXbottom, WB, RD, WR, RW, RW0, CMP
    localparam logic [8:0] F_IF = 9'h100, F_EXT = 9'h080, F_EXB = 9'h040, F_WB = 9'h020,
                           F_RD = 9'h010, F_WR = 9'h008, F_RW = 9'h004, F_RW0 = 9'h002,
                           F_CMP = 9'h001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] oppcode = 4'h0;
    logic [3:0] functionCode = 4'h0;
    logic       branch_taken = 1'b0;
    logic       stall_in = 1'b0;
    logic [3:0] functCode;
    logic [1:0] signExtend;
    logic       muxIF, muxEXtop, muxEXbottom, muxWB, memRead, memWrite;
    logic       regWrite, regWrite0, comparator, valid_out, stall_out, halted, illegal;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int         m_busy;
    bit         m_halt;
    logic       e_valid, e_ill;
    logic [3:0] e_fn;
    logic [1:0] e_se;
    logic [8:0] e_fl;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.MULDIV_CYC(MDC), .OP_W(4), .FN_W(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .oppcode(oppcode),
        .functionCode(functionCode), .branch_taken(branch_taken), .stall_in(stall_in),
        .functCode(functCode), .signExtend(signExtend), .muxIF(muxIF), .muxEXtop(muxEXtop),
        .muxEXbottom(muxEXbottom), .muxWB(muxWB), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .regWrite0(regWrite0), .comparator(comparator),
        .valid_out(valid_out), .stall_out(stall_out), .halted(halted), .illegal(illegal)
    );

    logic [17:0] dut_vec;
    assign dut_vec = {valid_out, illegal, halted, functCode, signExtend, muxIF, muxEXtop,
                      muxEXbottom, muxWB, memRead, memWrite, regWrite, regWrite0, comparator};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic void ref_dec(input logic [3:0] op, input logic [3:0] fn,
                                    output int kind, output logic [3:0] rfn,
                                    output logic [1:0] se, output logic [8:0] fl);
        kind = K_OP; rfn = 4'hF; se = 2'b00; fl = 9'h000;
        case (op)
            4'h0: begin
                rfn = fn;
                if (fn inside {4'hF, 4'hE, 4'hD, 4'hC})      fl = F_WB | F_RW;
                else if (fn inside {4'h1, 4'h2}) begin       fl = F_WB | F_RW0; kind = K_MD; end
                else if (fn inside {4'hA, 4'hB, 4'h8, 4'h9}) fl = F_EXB | F_WB | F_RW;
                else begin kind = K_ILL; rfn = 4'hF; end
            end
            4'h8:             begin se = 2'b01; fl = F_EXT | F_RD | F_RW; end
            4'hB:             begin se = 2'b01; fl = F_EXT | F_WR; end
            4'h4, 4'h5, 4'h6: begin se = 2'b10; fl = F_CMP; rfn = 4'hE; end
            4'hC:             begin se = 2'b11; fl = F_IF; end
            4'hF:             kind = K_HALT;
            default:          kind = K_ILL;
        endcase
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_halt = 0;
        e_valid = 0; e_ill = 0; e_fn = 4'hF; e_se = 2'b00; e_fl = 9'h000;
    endfunction

    // One clock: drive inputs, check stall_out, advance model, check registered outputs.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] fn,
                       input logic br, input logic st, input logic r);
        int kind; logic [3:0] rfn; logic [1:0] se; logic [8:0] fl;
        valid_in = v; oppcode = op; functionCode = fn;
        branch_taken = br; stall_in = st; rst = r;
        #1;
        chk("stall_out", 32'(stall_out), 32'(m_halt || (m_busy > 0)));
        if (r) begin
            model_reset();
        end else if (!st) begin
            e_valid = 0; e_fn = 4'hF; e_se = 2'b00; e_fl = 9'h000;
`ifndef ILLEGAL_TRAP_EN
            e_ill = 0;
`endif
            if (m_halt) begin
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (br) begin
            end else if (v) begin
                ref_dec(op, fn, kind, rfn, se, fl);
                if (kind == K_ILL) begin
                    e_ill = 1;
`ifdef ILLEGAL_TRAP_EN
                    m_halt = 1;
`endif
                end else if (kind == K_HALT) begin
                    m_halt = 1;
                end else begin
                    e_valid = 1; e_fn = rfn; e_se = se; e_fl = fl;
                    if (kind == K_MD) m_busy = MDC - 1;
                end
            end
        end
        @(posedge clk); #1;
        chk("outputs", 32'(dut_vec), 32'({e_valid, e_ill, m_halt, e_fn, e_se, e_fl}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Issue a mul, then count stall_out cycles (bounded), stalling on 2 of them if asked.
    task automatic md_len(input logic with_stall, input int exp_len, input string tag);
        int n = 0;
        cyc(1'b1, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && stall_out; k++) begin
            n++;
            cyc(1'b1, 4'h0, 4'hF, 1'b0, with_stall && (k == 1 || k == 2), 1'b0);
        end
        chk(tag, 32'(n), 32'(exp_len));
    endtask

    initial begin
        int hcnt;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // reset state, including reset with stall_in high
        cyc(1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b1);
        chk("rst_valid", 32'(valid_out), 32'd0);

        // ALU add -> functCode F, muxWB, regWrite, valid
        cyc(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("alu_add", 32'({valid_out, functCode, muxWB, regWrite}), 32'({1'b1, 4'hF, 1'b1, 1'b1}));
        // every decodable class once
        cyc(1'b1, 4'h8, 4'h3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'hB, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0);
        // stall_in holds the previous bundle
        cyc(1'b1, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0);
        idle(1);

        // mul/div occupancy, plain and with 2 stalled cycles
        md_len(1'b0, MDC - 1, "md_len3");
        idle(1);
        md_len(1'b1, MDC + 1, "md_len5");
        idle(1);

        // branch squashes a halt; next instruction still accepted
        cyc(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("br_halt", 32'({halted, valid_out}), 32'd0);
        cyc(1'b1, 4'h0, 4'hD, 1'b0, 1'b0, 1'b0);
        chk("br_next", 32'(valid_out), 32'd1);

        // halt, stays halted, reset clears in one cycle
        cyc(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("halted", 32'({halted, stall_out}), 32'b11);
        cyc(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("halt_hold", 32'({halted, valid_out}), 32'b10);
        cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("halt_rst", 32'({halted, stall_out}), 32'd0);

        // illegal opcode
        cyc(1'b1, 4'h7, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("ill_set", 32'(illegal), 32'd1);
        cyc(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap", 32'({illegal, halted}), 32'b11);
`else
        chk("ill_pulse", 32'({illegal, halted}), 32'b00);
`endif
        cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // reset mid-MULDIV with counter at 2
        cyc(1'b1, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("md_rst", 32'(stall_out), 32'd0);

        // randomized traffic
        hcnt = 0;
        for (int i = 0; i < 1500; i++) begin
            logic r;
            hcnt = m_halt ? hcnt + 1 : 0;
            r = (hcnt > 3) || ($urandom_range(0, 99) < 1);
            cyc($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 15, r);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter MULDIV_CYC, default 4, meaning the total EX occupancy in cycles of multiply/divide (legal range 1..15).
REQ-002 SHALL have parameter OP_W, default 4, meaning the opcode width.
REQ-003 SHALL have parameter FN_W, default 4, meaning the function-code width.
REQ-004 SHALL have one clock and a synchronous, active-high reset (already decided); ports clk and rst, listed first.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst  input  1  synchronous reset, active high.
REQ-007 SHALL have port valid_in  input  1  an ID-stage instruction is present.
REQ-008 SHALL have port oppcode  input  OP_W  opcode.
REQ-009 SHALL have port functionCode  input  FN_W  R-type function code.
REQ-010 SHALL have port branch_taken  input  1  EX resolved a taken branch or jump, so squash ID.
REQ-011 SHALL have port stall_in  input  1  downstream hold (memory wait).
REQ-012 SHALL have port functCode  output  FN_W  ALU function, registered.
REQ-013 SHALL have port signExtend  output  2  immediate select, registered.
REQ-014 SHALL have ports muxIF, muxEXtop, muxEXbottom, muxWB, memRead, memWrite, regWrite, regWrite0, comparator  output  1 each  registered control bundle.
REQ-015 SHALL have port valid_out  output  1  bundle is a real instruction (0 = bubble).
REQ-016 SHALL have port stall_out  output  1  hold PC and IF/ID.
REQ-017 SHALL have port halted  output  1  core halted.
REQ-018 SHALL have port illegal  output  1  undecodable instruction seen.

Function
REQ-019 SHALL decode opcode 0000 with funct F/E/D/C to ALU ops, funct 1/2 to mul/div (regWrite0=1), and funct A/B/8/9 to shift/rotate (signExtend=00, muxEXbottom=1); 1000 to load, 1011 to store, 0100/0101/0110 to branch (signExtend=10, comparator=1), 1100 to jump (muxIF=1), and 1111 to halt.
REQ-020 SHALL drive no X on any output; every don't-care is 0 and a bubble bundle is all-zero with functCode=1111.
REQ-021 SHALL register the decoded bundle one cycle after acceptance (latency 1); accept = valid_in & !stall_in & !stall_out & state==RUN.
REQ-022 SHALL hold all registered outputs unchanged while stall_in=1.
REQ-023 SHALL implement FSM states RUN, MULDIV, HALT.
REQ-024 SHALL, on RUN with mul/div accepted, issue the bundle, load the counter with MULDIV_CYC-1, and enter MULDIV if the load value is >0, else remain in RUN.
REQ-025 SHALL, in MULDIV, assert stall_out, emit bubbles, decrement the counter per cycle unless stall_in=1, and return to RUN when the counter reaches 0 (stall_out low that cycle).
REQ-026 SHALL, when halt is accepted, issue a bubble, enter HALT, and set halted=1 the next cycle; HALT exits only on rst; stall_out=1 in HALT.
REQ-027 SHALL give branch_taken priority over accept: the next bundle is a bubble, no state change occurs, and MULDIV/HALT entry is cancelled.
REQ-028 SHALL ignore branch_taken in MULDIV, since the instruction is already issued.
REQ-029 SHALL treat an undecodable opcode or R-type funct as a bubble and pulse illegal for one cycle.

Reset
REQ-030 SHALL, on rst, go to state RUN with counter=0, all bundle outputs at bubble value, and valid_out, stall_out, halted, illegal all 0, regardless of state or stall_in.

Configuration
REQ-031 SHALL, when ILLEGAL_TRAP_EN is defined, make an illegal instruction enter HALT with illegal sticky high until rst.
REQ-032 SHALL, when ILLEGAL_TRAP_EN is undefined, make an illegal instruction behave as in REQ-029 and continue execution.

Structure
REQ-033 SHALL place opcode/funct localparams, the FSM state encoding and the bubble-bundle constant in shared package cpu_ctrl_pkg.
REQ-034 SHALL implement decode as combinational sub-module ctrl_decode (oppcode, functionCode -> bundle, is_muldiv, is_halt, is_illegal); sequencing stays in pipe_ctrl_unit.

Verification
REQ-035 SHALL cover: opcode 0000/funct 1111 accepted -> next cycle functCode=1111, muxWB=1, regWrite=1, valid_out=1.
REQ-036 SHALL cover: funct 0001 with MULDIV_CYC=4 -> one issue, then stall_out=1 for exactly 3 cycles, then RUN; with stall_in high for 2 of those cycles -> stall_out lasts 5 cycles.
REQ-037 SHALL cover: branch_taken=1 in the same cycle as halt 1111 -> bubble, halted stays 0, next instruction accepted.
REQ-038 SHALL cover: halt 1111 -> halted=1 and stall_out=1 forever; rst -> all outputs return to reset values in 1 cycle.
REQ-039 SHALL cover: opcode 0111 -> illegal pulses 1 cycle (macro off) or halted=1 with illegal sticky (ILLEGAL_TRAP_EN on).
REQ-040 SHALL cover: rst asserted mid-MULDIV (counter=2) -> RUN, stall_out=0 next cycle.
